// File: rtl/aes_sbox_pkg.sv
// AES S-box tables and helpers shared by the SubBytes engine and its lane lookups.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Contents: state enum, forward/inverse FIPS-197 tables, sbox_lookup(), calc_nbeats().
package aes_sbox_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sb_state_e;

    // Element 0 is the leftmost byte, so SBOX_FWD[b] = SBOX[b[7:4]][b[3:0]].
    localparam logic [0:255][7:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic int calc_nbeats(input int data_w, input int lanes);
        return data_w / (8 * lanes);
    endfunction

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b, input logic inv);
        return inv ? SBOX_INV[b] : SBOX_FWD[b];
    endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// Single-byte AES S-box lookup (forward, plus inverse when SBOX_INV_EN is defined).
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: i_byte (byte in), i_inv (1 = inverse table), o_byte (substituted byte).
// Macro SBOX_INV_EN: when undefined only the forward table is built and i_inv is ignored.
module aes_sbox_byte
    import aes_sbox_pkg::*;
(
    input  logic [7:0] i_byte,
    input  logic       i_inv,
    output logic [7:0] o_byte
);

`ifdef SBOX_INV_EN
    assign o_byte = sbox_lookup(i_byte, i_inv);
`else
    logic w_unused_inv;
    assign w_unused_inv = i_inv;
    assign o_byte       = SBOX_FWD[i_byte];
`endif

endmodule

// File: rtl/sub_bytes_iter.sv
// Time-multiplexed AES SubBytes: substitutes LANES bytes of the held state word per clock.
// Latency: word accepted on edge T presents out_valid on edge T+NBEATS.
// Backpressure: result held in DONE until out_ready; a new word may load in the draining cycle.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data/in_inv input side;
//        out_valid/out_ready/out_data output side; busy = RUN or DONE.
// Macro SBOX_INV_EN: adds a per-word mode register selecting forward or inverse S-box.
module sub_bytes_iter
    import aes_sbox_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int LANES  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam int NBEATS = calc_nbeats(DATA_W, LANES);
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    if ((DATA_W % 8) != 0 || LANES < 1 || ((DATA_W / 8) % LANES) != 0) begin : g_bad_param
        $error("sub_bytes_iter: DATA_W must be a multiple of 8 and LANES must divide DATA_W/8");
    end

    sb_state_e         r_state;
    sb_state_e         w_state_nxt;
    logic [BEAT_W-1:0] r_beat;
    logic [DATA_W-1:0] r_work;
    logic [DATA_W-1:0] w_next_work;
    logic              w_accept;
    logic              w_last;
    logic              w_mode;
    logic [7:0]        w_lane_in  [LANES];
    logic [7:0]        w_lane_out [LANES];

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_beat == LAST_BEAT);

`ifdef SBOX_INV_EN
    logic r_inv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inv <= 1'b0;
        end else if (w_accept) begin
            r_inv <= in_inv;
        end
    end

    assign w_mode = r_inv;
`else
    logic w_unused_inv;
    assign w_unused_inv = in_inv;
    assign w_mode       = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)   w_state_nxt = ST_DONE;
            ST_DONE: begin
                // Drain and accept in the same cycle goes straight back to RUN.
                if (w_accept)       w_state_nxt = ST_RUN;
                else if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
        out_valid = (r_state == ST_DONE);
        busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
    end

    assign out_data = r_work;

    // Lane inputs: the current beat's byte group, low bytes first.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_lane_in[l] = r_work[(int'(r_beat) * LANES + l) * 8 +: 8];
        end
    end

    // Kept separate from the lane-input block so the lookup is not seen as a loop.
    always_comb begin
        w_next_work = r_work;
        for (int l = 0; l < LANES; l++) begin
            w_next_work[(int'(r_beat) * LANES + l) * 8 +: 8] = w_lane_out[l];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_sbox_byte u_sbox (
            .i_byte (w_lane_in[g]),
            .i_inv  (w_mode),
            .o_byte (w_lane_out[g])
        );
    end

    // Working register and beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
            r_beat <= '0;
        end else if (w_accept) begin
            r_work <= in_data;
            r_beat <= '0;
        end else if (r_state == ST_RUN) begin
            r_work <= w_next_work;
            r_beat <= w_last ? '0 : r_beat + BEAT_W'(1);
        end
    end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Self-checking bench for sub_bytes_iter at LANES = 4, 16 and 1 (DATA_W = 128).
// Reference S-box is derived from GF(2^8) inversion plus the AES affine map.
module tb_sub_bytes_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   vld;
    wire  [2:0]   rdy, ov, bz;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_ready;
    wire  [127:0] od0, od1, od2;

    int checks   = 0;
    int failures = 0;
    int cnt      = 0;

    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    bit           have    [3];
    logic [127:0] exp_dat [3];
    int           due     [3];
    int           pops    [3];
    int           nb      [3];
    bit           rnd_on;

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    sub_bytes_iter #(.DATA_W(128), .LANES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(in_data),
        .in_inv(in_inv), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0), .busy(bz[0]));
    sub_bytes_iter #(.DATA_W(128), .LANES(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(in_data),
        .in_inv(in_inv), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1), .busy(bz[1]));
    sub_bytes_iter #(.DATA_W(128), .LANES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy[2]), .in_data(in_data),
        .in_inv(in_inv), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od2), .busy(bz[2]));

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [127:0] sub_word(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i*8 +: 8] = inv ? inv_t[d[i*8 +: 8]] : fwd_t[d[i*8 +: 8]];
        end
        return r;
    endfunction

    function automatic logic [127:0] get_od(input int k);
        return (k == 0) ? od0 : (k == 1) ? od1 : od2;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle-level model: at most one word in flight per engine.
    always @(negedge clk) begin : cmp
        logic eov, erdy;
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) have[k] = 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                eov  = have[k] && (cnt >= due[k]);
                erdy = !have[k] || (eov && out_ready);
                chk($sformatf("out_valid[%0d]@%0d", k, cnt), 128'(ov[k]), 128'(eov));
                chk($sformatf("in_ready[%0d]@%0d", k, cnt), 128'(rdy[k]), 128'(erdy));
                chk($sformatf("busy[%0d]@%0d", k, cnt), 128'(bz[k]), 128'(have[k]));
                if (eov) chk($sformatf("out_data[%0d]@%0d", k, cnt), get_od(k), exp_dat[k]);
                if (eov && out_ready) begin
                    have[k] = 1'b0;
                    pops[k]++;
                end
                if (vld[k] && erdy) begin
                    have[k] = 1'b1;
`ifdef SBOX_INV_EN
                    exp_dat[k] = sub_word(in_data, in_inv);
`else
                    exp_dat[k] = sub_word(in_data, 1'b0);
`endif
                    due[k] = cnt + 1 + nb[k];
                end
            end
        end
    end

    // Presents one word to engine k, waits for its result; optionally flips in_inv after accept.
    task automatic xfer(input int k, input logic [127:0] d, input logic inv, input logic flip,
                        output int lat, output logic [127:0] res);
        int t = 0;
        @(posedge clk); #1;
        in_data = d; in_inv = inv; vld[k] = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy[k] || t > 200) break;
            t++;
        end
        if (t > 200) chk("accept_timeout", 128'(t), 128'(0));
        @(posedge clk); #1;
        vld[k] = 1'b0;
        if (flip) in_inv = ~inv;
        lat = 0;
        while (!ov[k] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = get_od(k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    localparam logic [127:0] V1 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] R1 = 128'hd42711aee0bf98f1b8b45de51e415230;

    initial begin
        int           lat;
        logic [127:0] res, held;
        int           t, p0;
        logic [7:0]   y;

        rst_n = 1'b0; vld = '0; in_data = '0; in_inv = 1'b0; out_ready = 1'b1; rnd_on = 1'b0;
        nb[0] = 4; nb[1] = 1; nb[2] = 16;
        for (int k = 0; k < 3; k++) begin have[k] = 0; pops[k] = 0; due[k] = 0; end

        // Reference tables from first principles.
        for (int x = 0; x < 256; x++) begin
            y = 8'h00;
            for (int c = 1; c < 256; c++) if (gf_mul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
            fwd_t[x] = y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);
        chk("model_fwd_00", 128'(fwd_t[8'h00]), 128'h63);
        chk("model_fwd_53", 128'(fwd_t[8'h53]), 128'hed);
        chk("model_fwd_ff", 128'(fwd_t[8'hff]), 128'h16);
        chk("model_inv_ed", 128'(inv_t[8'hed]), 128'h53);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_out_valid[%0d]", k), 128'(ov[k]), 128'(0));
            chk($sformatf("rst_out_data[%0d]", k), get_od(k), 128'(0));
            chk($sformatf("rst_busy[%0d]", k), 128'(bz[k]), 128'(0));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 chk("in_ready_after_reset", 128'(rdy[0]), 128'(1));

        // Single word, FIPS-197 vector
        xfer(0, V1, 1'b0, 1'b0, lat, res);
        chk("t1_latency", 128'(lat), 128'(4));
        chk("t1_data", res, R1);

        // Byte corners on every lane count
        for (int k = 0; k < 3; k++) begin
            xfer(k, '0, 1'b0, 1'b0, lat, res);
            chk($sformatf("t2_zero_lat[%0d]", k), 128'(lat), 128'((k == 0) ? 4 : (k == 1) ? 1 : 16));
            chk($sformatf("t2_zero_data[%0d]", k), res, {16{8'h63}});
            xfer(k, {8'hff, {14{8'h00}}, 8'h53}, 1'b0, 1'b0, lat, res);
            chk($sformatf("t2_corner_data[%0d]", k), res, {8'h16, {14{8'h63}}, 8'hed});
        end

        // Back-pressure then same-cycle drain and accept
        out_ready = 1'b0;
        xfer(0, V1, 1'b0, 1'b0, lat, held);
        chk("t3_first", held, R1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("t3_hold_data", od0, R1);
            chk("t3_hold_in_ready", 128'(rdy[0]), 128'(0));
        end
        out_ready = 1'b1; vld[0] = 1'b1; in_data = '0;
        @(negedge clk);
        chk("t3_drain_ready", 128'(rdy[0]), 128'(1));
        @(posedge clk); #1;
        vld[0] = 1'b0;
        chk("t3_reloaded_busy", 128'(bz[0]), 128'(1));
        t = 0;
        while (!ov[0] && t < 200) begin @(posedge clk); #1; t++; end
        chk("t3_second_latency", 128'(t), 128'(4));
        chk("t3_second_data", od0, {16{8'h63}});

        // Reset in the middle of RUN
        @(posedge clk); #1;
        vld[0] = 1'b1; in_data = V1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_out_valid", 128'(ov[0]), 128'(0));
        chk("t4_out_data", od0, 128'(0));
        chk("t4_busy", 128'(bz[0]), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        xfer(0, V1, 1'b0, 1'b0, lat, res);
        chk("t4_after_data", res, R1);

`ifdef SBOX_INV_EN
        // Inverse mode and mode capture at accept
        xfer(0, {16{8'h63}}, 1'b1, 1'b0, lat, res);
        chk("t5_inv_63", res, 128'(0));
        xfer(0, {{15{8'h00}}, 8'hed}, 1'b1, 1'b0, lat, res);
        chk("t5_inv_ed", res, {{15{8'h52}}, 8'h53});
        xfer(0, {16{8'h63}}, 1'b0, 1'b1, lat, res);
        chk("t5_flip_fwd", res, {16{8'hfb}});
        xfer(0, {16{8'h63}}, 1'b1, 1'b1, lat, res);
        chk("t5_flip_inv", res, 128'(0));
        in_inv = 1'b0;
`endif

        // Random streaming with random gaps on both sides
        @(posedge clk); #1;
        p0 = pops[0];
        rnd_on = 1'b1;
        fork
            begin
                for (int w = 0; w < 1000; w++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    in_data = {$urandom, $urandom, $urandom, $urandom};
                    in_inv  = 1'($urandom_range(0, 1));
                    vld[0]  = 1'b1;
                    t = 0;
                    forever begin
                        @(negedge clk);
                        if (rdy[0] || t > 200) break;
                        t++;
                    end
                    if (t > 200) chk("t6_accept_timeout", 128'(t), 128'(0));
                    @(posedge clk); #1;
                    vld[0] = 1'b0;
                end
                t = 0;
                while (pops[0] - p0 < 1000 && t < 500) begin @(posedge clk); #1; t++; end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("t6_words_out", 128'(pops[0] - p0), 128'(1000));
        chk("t6_none_left", 128'(have[0]), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
